// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shift_pkg                                                  |
// | Purpose : Shared definitions for the parallel-in / serial-out        |
// |           transmit register: FSM state encoding and the bit-counter  |
// |           width helper.                                              |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package shift_pkg;

  // Two-state transmit FSM, encoded in a single bit.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Width of a counter that must hold 0..n-1. Never returns less than one
  // bit so a degenerate width cannot produce a zero-width vector.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_n_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mod_n_counter                                              |
// | Purpose : Modulo-N up counter with enable and synchronous clear.     |
// |           Tracks the position of the bit currently on the serial     |
// |           line inside the word.                                      |
// | Ports   : clk    - rising-edge clock                                 |
// |           rst_n  - asynchronous active-low reset (count -> 0)        |
// |           clr    - synchronous clear, dominates enable               |
// |           en     - advance by one (wraps N-1 -> 0)                   |
// |           count  - current count, 0..N-1                             |
// |           tc     - terminal count flag, high when count == N-1       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mod_n_counter
  import shift_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  output logic [cnt_width(N)-1:0] count,
  output logic                    tc
);

  localparam int W = cnt_width(N);
  localparam logic [W-1:0] c_max  = W'(N - 1);
  localparam logic [W-1:0] c_one  = W'(1);
  localparam logic [W-1:0] c_zero = '0;

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= c_zero;
    end else if (clr) begin
      r_count <= c_zero;
    end else if (en) begin
      // Explicit wrap keeps the count inside 0..N-1 for non-power-of-2 N.
      r_count <= (r_count == c_max) ? c_zero : (r_count + c_one);
    end
  end

  assign count = r_count;
  assign tc    = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/piso_shift_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : piso_shift_register                                        |
// | Purpose : Parallel-in, serial-out transmit register. Accepts an      |
// |           N-bit word over a valid/ready handshake and emits it one   |
// |           bit per enabled clock, with stall support and gap-free     |
// |           back-to-back words.                                        |
// | Ports   : clk        - rising-edge clock                             |
// |           rst_n      - asynchronous active-low reset                 |
// |           din        - parallel word, sampled on an accepted load    |
// |           load_valid - din holds a word to send                      |
// |           load_ready - a word can be accepted this cycle             |
// |           shift_en   - downstream consumes the current bit           |
// |           sout       - current serial bit                            |
// |           sout_valid - sout carries a valid bit                      |
// |           last       - current bit is the final bit of the word      |
// |           done       - one-cycle pulse after the final bit is        |
// |                        consumed with no new word following           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module piso_shift_register
  import shift_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         last,
  output logic         done
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] c_cnt_max = CW'(N - 1);

  state_t        r_state;
  logic [N-1:0]  r_shreg;
  logic          r_done;

  logic [N-1:0]  w_shifted;
  logic          w_out_bit;
  logic [CW-1:0] w_count;
  logic          w_tc;
  logic          w_in_shift;
  logic          w_word_end;
  logic          w_accept;
  logic          w_cnt_clr;
  logic          w_cnt_en;

  // ------------------------------------------------------------------
  // Bit ordering: the output end of the register and the shift
  // direction both depend on MSB_FIRST. Vacated bits are zero-filled.
  // ------------------------------------------------------------------
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_out_bit = r_shreg[N-1];
      assign w_shifted = {r_shreg[N-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit = r_shreg[0];
      assign w_shifted = {1'b0, r_shreg[N-1:1]};
    end
  endgenerate

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  assign w_in_shift = (r_state == ST_SHIFT);

  // The final bit is being consumed this cycle: the register frees up,
  // so a new word may be taken on the same edge without a bubble.
  assign w_word_end = w_in_shift && w_tc && shift_en;

  assign load_ready = (r_state == ST_IDLE) || w_word_end;
  assign w_accept   = load_valid && load_ready;

  // Clearing at every word end (not only on reload) leaves the counter
  // at zero in IDLE, so last cannot be left asserted after a word.
  assign w_cnt_clr = w_accept || w_word_end;
  assign w_cnt_en  = w_in_shift && shift_en && (w_count != c_cnt_max);

  mod_n_counter #(
    .N (N)
  ) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .en    (w_cnt_en),
    .count (w_count),
    .tc    (w_tc)
  );

  // ------------------------------------------------------------------
  // FSM and shift register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // shift_en is deliberately ignored here.
          if (load_valid) begin
            r_shreg <= din;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (w_tc) begin
              if (load_valid) begin
                // Back-to-back reload: stay in SHIFT, no done pulse.
                r_shreg <= din;
              end else begin
                r_shreg <= '0;
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_shreg <= w_shifted;
            end
          end
          // shift_en low: everything holds (stall of any length).
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs: decoded from registered state only, never from inputs.
  // ------------------------------------------------------------------
  assign sout_valid = w_in_shift;
  assign sout       = w_in_shift && w_out_bit;
  assign last       = w_in_shift && w_tc;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_piso_shift_register                                     |
// | Purpose : Self-checking bench for piso_shift_register. Two instances |
// |           (MSB-first and LSB-first) share the same stimulus; a       |
// |           word-level model queues the expected serial bits and a     |
// |           monitor compares them as the DUTs present them.            |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_piso_shift_register;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic rdy_m, sout_m, sv_m, last_m, done_m;
  logic rdy_l, sout_l, sv_l, last_l, done_l;

  piso_shift_register #(.N(N), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(rdy_m), .shift_en(shift_en), .sout(sout_m),
    .sout_valid(sv_m), .last(last_m), .done(done_m)
  );

  piso_shift_register #(.N(N), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(rdy_l), .shift_en(shift_en), .sout(sout_l),
    .sout_valid(sv_l), .last(last_l), .done(done_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic l;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];

  int   checks   = 0;
  int   failures = 0;

  // Word-level model: number of bits of the current word not yet consumed.
  int   pend      = 0;
  logic exp_valid = 1'b0;
  logic exp_ready = 1'b1;
  logic exp_done  = 1'b0;
  logic done_next = 1'b0;
  logic accepted  = 1'b0;
  logic mon_en    = 1'b0;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; updates the model for the cycle it drives.
  task automatic step(input logic lv, input logic [N-1:0] d, input logic se);
    logic fin;
    @(posedge clk);
    #1;
    load_valid = lv;
    din        = d;
    shift_en   = se;
    exp_valid  = (pend > 0);
    exp_done   = done_next;
    exp_ready  = (pend == 0) || (pend == 1 && se);
    done_next  = 1'b0;
    fin        = se && (pend == 1);
    if (se && pend > 0) pend--;
    accepted = lv && exp_ready;
    if (accepted) begin
      for (int i = 0; i < N; i++) begin
        q_m.push_back(exp_t'{d[N-1-i], (i == N-1)});
        q_l.push_back(exp_t'{d[i],     (i == N-1)});
      end
      pend = N;
    end else if (fin) begin
      done_next = 1'b1;
    end
  endtask

  // Monitor: compares control outputs every cycle and pops the expected
  // bit whenever a DUT shows a valid bit that is consumed.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("load_ready_msb", rdy_m, exp_ready);
      chk("load_ready_lsb", rdy_l, exp_ready);
      chk("sout_valid_msb", sv_m, exp_valid);
      chk("sout_valid_lsb", sv_l, exp_valid);
      chk("done_msb", done_m, exp_done);
      chk("done_lsb", done_l, exp_done);
      if (!exp_valid) begin
        chk("idle_sout_msb", sout_m, 1'b0);
        chk("idle_last_lsb", last_l, 1'b0);
      end
      if (sv_m) begin
        if (q_m.size() == 0) chk("unexpected_bit_msb", 1'b1, 1'b0);
        else begin
          chk("sout_msb", sout_m, q_m[0].b);
          chk("last_msb", last_m, q_m[0].l);
          if (shift_en) void'(q_m.pop_front());
        end
      end
      if (sv_l) begin
        if (q_l.size() == 0) chk("unexpected_bit_lsb", 1'b1, 1'b0);
        else begin
          chk("sout_lsb", sout_l, q_l[0].b);
          chk("last_lsb", last_l, q_l[0].l);
          if (shift_en) void'(q_l.pop_front());
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < N + 3; i++) step(1'b0, '0, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sout_msb"}, sout_m, 1'b0);
    chk({tag, "_sout_lsb"}, sout_l, 1'b0);
    chk({tag, "_valid_msb"}, sv_m, 1'b0);
    chk({tag, "_valid_lsb"}, sv_l, 1'b0);
    chk({tag, "_last_msb"}, last_m, 1'b0);
    chk({tag, "_done_msb"}, done_m, 1'b0);
    chk({tag, "_ready_msb"}, rdy_m, 1'b1);
  endtask

  logic         offering;
  logic [N-1:0] offer;

  initial begin
    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk_all_zero("reset");
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, '0, logic'(i % 2));

    // Basic word 1011: MSB 1,0,1,1 / LSB 1,1,0,1, then done
    step(1'b1, 4'b1011, 1'b1);
    drain();

    // Stall on first and last bit of 1001
    step(1'b1, 4'b1001, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    drain();

    // Back-to-back 1100 then 0011 offered continuously mid-shift
    step(1'b1, 4'b1100, 1'b1);
    for (int i = 0; i < N; i++) step(1'b1, 4'b0011, 1'b1);
    drain();

    // Reset mid-word after the second bit of 1111
    step(1'b1, 4'b1111, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    @(posedge clk);
    #1 mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    q_m.delete();
    q_l.delete();
    pend = 0; done_next = 1'b0;
    exp_valid = 1'b0; exp_ready = 1'b1; exp_done = 1'b0;
    load_valid = 1'b0; shift_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_reset_done_msb", done_m, 1'b0);
    mon_en = 1'b1;
    step(1'b1, 4'b0101, 1'b1);
    drain();

    // Randomised traffic; the source holds a word until it is accepted.
    offering = 1'b0;
    offer    = '0;
    for (int i = 0; i < 400; i++) begin
      if (!offering && $urandom_range(0, 2) == 0) begin
        offering = 1'b1;
        offer    = N'($urandom);
      end
      step(offering, offering ? offer : N'($urandom), logic'($urandom_range(0, 3) != 0));
      if (accepted) offering = 1'b0;
    end
    drain();

    chk("drained_msb", logic'(q_m.size() == 0), 1'b1);
    chk("drained_lsb", logic'(q_l.size() == 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
